pc_fetch_ctrl: RTL and testbench

//   Fetch sequencer that owns the program counter and schedules instruction-memory

---
 rtl/pc_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, arbitrates next-PC source, runs one-outstanding imem req/gnt/rvalid.
// Latency: response-to-instr_valid 1 cycle, redirect-to-request 1 cycle; optional PC_MISALIGN_TRAP_EN.
// Backpressure: stall_i holds the one-entry decode buffer and withholds imem_req_o while it is full.
module pc_fetch_ctrl #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = 32'hBFC00000,
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = 32'hBFC00380
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                trap_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [PC_WIDTH-1:0]   pc, pc_nxt;
    logic                  kill, kill_nxt;
    logic                  valid, valid_nxt;
    logic [31:0]           instr, instr_nxt;
    logic [PC_WIDTH-1:0]   instr_pc, instr_pc_nxt;
    logic                  misalign, misalign_nxt;

    logic                  buf_free;
    logic                  req;
    logic                  grant;
    logic                  flush;
    logic                  mis_hit;
    logic [PC_WIDTH-1:0]   target;

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_pc_low;
    assign unused_pc_low = ^redirect_pc_i[1:0];
`endif

    always_comb begin
        mis_hit = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        mis_hit = redirect_i && !trap_i && (redirect_pc_i[1:0] != 2'b00);
        target  = (trap_i || mis_hit) ? TRAP_VECTOR : redirect_pc_i;
`else
        target  = trap_i ? TRAP_VECTOR : {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
`endif
    end

    always_comb begin
        buf_free = !valid || !stall_i;
        req      = (state == ST_REQ) && buf_free;
        grant    = req && imem_gnt_i;
        flush    = (state != ST_BOOT) && (trap_i || redirect_i);
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        kill_nxt     = kill;
        valid_nxt    = valid;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        misalign_nxt = 1'b0;

        if (valid && !stall_i) begin
            valid_nxt = 1'b0;
        end

        case (state)
            ST_BOOT: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (grant) begin
                    state_nxt = ST_WAIT;
                    kill_nxt  = flush;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    state_nxt = ST_REQ;
                    kill_nxt  = 1'b0;
                    // A response issued before a redirect belongs to the old stream.
                    if (!kill && !flush) begin
                        valid_nxt    = 1'b1;
                        instr_nxt    = imem_rdata_i;
                        instr_pc_nxt = pc;
                        pc_nxt       = pc + PC_WIDTH'(4);
                    end
                end else if (flush) begin
                    kill_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase

        if (flush) begin
            pc_nxt       = target;
            valid_nxt    = 1'b0;
            misalign_nxt = mis_hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_BOOT;
            pc       <= RESET_VECTOR;
            kill     <= 1'b0;
            valid    <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            kill     <= kill_nxt;
            valid    <= valid_nxt;
            instr    <= instr_nxt;
            instr_pc <= instr_pc_nxt;
            misalign <= misalign_nxt;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign instr_valid_o = valid;
    assign instr_o       = instr;
    assign instr_pc_o    = instr_pc;
    assign misalign_o    = misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] TV = 32'hBFC00380;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, trap = 1'b0, gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] redirect_pc = '0, rdata = '0;
    logic        req, ivalid, mis;
    logic [31:0] addr, instr, ipc, pc;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .trap_i(trap), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(ivalid), .instr_o(instr), .instr_pc_o(ipc), .pc_o(pc), .misalign_o(mis)
    );

    always #5 clk = ~clk;

    task automatic clr();
        stall = 0; redirect = 0; trap = 0; gnt = 0; rvalid = 0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; clr(); nxt(); #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", req); end
        n_checks++; if (pc !== RV) begin n_fail++; $display("FAIL rst_pc got %h want %h", pc, RV); end
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ivalid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", instr); end
        n_checks++; if (ipc !== 32'h0) begin n_fail++; $display("FAIL rst_ipc got %h want 0", ipc); end
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL rst_mis got %b want 0", mis); end
        rst_n = 1; #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL boot_req got %b want 0", req); end
        nxt(); #1;
        n_checks++; if (req !== 1'b1 || addr !== RV) begin n_fail++; $display("FAIL first_req got %b/%h want 1/%h", req, addr, RV); end
    endtask

    task automatic test_basic_fetch();
        nxt(); gnt = 1; #1;
        n_checks++; if (req !== 1'b1 || addr !== RV) begin n_fail++; $display("FAIL fetch_req got %b/%h want 1/%h", req, addr, RV); end
        nxt(); gnt = 0; rvalid = 1; rdata = 32'h00000013; #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL wait_req got %b want 0", req); end
        nxt(); rvalid = 0; #1;
        n_checks++; if (ivalid !== 1'b1 || instr !== 32'h13 || ipc !== RV) begin
            n_fail++; $display("FAIL fetch_instr got %b/%h/%h want 1/00000013/%h", ivalid, instr, ipc, RV); end
        n_checks++; if (req !== 1'b1 || addr !== RV + 4) begin n_fail++; $display("FAIL seq_addr got %b/%h want 1/%h", req, addr, RV + 4); end
        nxt(); #1;
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL consume got %b want 0", ivalid); end
    endtask

    task automatic test_stall();
        nxt(); gnt = 1; #1;
        n_checks++; if (addr !== RV + 4) begin n_fail++; $display("FAIL stall_req_addr got %h want %h", addr, RV + 4); end
        nxt(); gnt = 0; rvalid = 1; rdata = 32'h00100093;
        for (int i = 0; i < 3; i++) begin
            nxt(); rvalid = 0; stall = 1; gnt = 1; #1;
            n_checks++; if (ivalid !== 1'b1 || instr !== 32'h00100093 || ipc !== RV + 4 || req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%h req=%b", i, ivalid, instr, ipc, req); end
        end
        nxt(); stall = 0; gnt = 0; #1;
        n_checks++; if (req !== 1'b1 || addr !== RV + 8 || ivalid !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got req=%b addr=%h v=%b want 1/%h/1", req, addr, ivalid, RV + 8); end
        nxt(); #1;
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL stall_consume got %b want 0", ivalid); end
    endtask

    task automatic test_redirect_wait();
        nxt(); gnt = 1; #1;
        n_checks++; if (addr !== RV + 8) begin n_fail++; $display("FAIL rdw_addr got %h want %h", addr, RV + 8); end
        nxt(); gnt = 0; redirect = 1; redirect_pc = 32'h80000100;
        nxt(); redirect = 0; rvalid = 1; rdata = 32'hDEADBEEF; #1;
        n_checks++; if (req !== 1'b0 || ivalid !== 1'b0) begin n_fail++; $display("FAIL rdw_kill got req=%b v=%b want 0/0", req, ivalid); end
        nxt(); rvalid = 0; #1;
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rdw_drop got %b want 0", ivalid); end
        n_checks++; if (req !== 1'b1 || addr !== 32'h80000100) begin n_fail++; $display("FAIL rdw_target got %b/%h want 1/80000100", req, addr); end
    endtask

    task automatic test_trap_priority();
        trap = 1; redirect = 1; redirect_pc = 32'h80000200;
        nxt(); trap = 0; redirect = 0; #1;
        n_checks++; if (req !== 1'b1 || addr !== TV) begin n_fail++; $display("FAIL trap_prio got %b/%h want 1/%h", req, addr, TV); end
    endtask

    task automatic test_misalign();
        logic [31:0] want;
        want = MIS_EN ? TV : 32'h80000100;
        redirect = 1; redirect_pc = 32'h80000102;
        nxt(); redirect = 0; #1;
        n_checks++; if (mis !== MIS_EN) begin n_fail++; $display("FAIL mis_pulse got %b want %b", mis, MIS_EN); end
        n_checks++; if (req !== 1'b1 || addr !== want) begin n_fail++; $display("FAIL mis_addr got %b/%h want 1/%h", req, addr, want); end
        nxt(); #1;
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %b want 0", mis); end
    endtask

    task automatic test_reset_mid();
        nxt(); gnt = 1;
        nxt(); gnt = 0; rst_n = 0; #1;
        n_checks++; if (req !== 1'b0 || pc !== RV || instr !== 32'h0 || ipc !== 32'h0) begin
            n_fail++; $display("FAIL midrst got req=%b pc=%h i=%h ipc=%h", req, pc, instr, ipc); end
        nxt(); rst_n = 1; rvalid = 1; rdata = 32'h12345678; redirect = 1; redirect_pc = 32'h80000400; #1;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL midrst_boot got %b want 0", req); end
        nxt(); redirect = 0; #1;
        n_checks++; if (req !== 1'b1 || addr !== RV || ivalid !== 1'b0) begin
            n_fail++; $display("FAIL boot_ignore got req=%b addr=%h v=%b want 1/%h/0", req, addr, ivalid, RV); end
        nxt(); rvalid = 0; #1;
        n_checks++; if (ivalid !== 1'b0 || addr !== RV) begin n_fail++; $display("FAIL late_rvalid got v=%b addr=%h", ivalid, addr); end
    endtask

    task automatic test_random();
        bit          boot, outs, okill, bvld, exp_req, exp_mis, flush, mcase;
        logic [31:0] exp_addr, oaddr, bpc, bdat, tgt, r;
        rst_n = 0; clr(); nxt(); rst_n = 1;
        boot = 1; outs = 0; okill = 0; bvld = 0; exp_mis = 0; exp_addr = RV; oaddr = 0; bpc = 0; bdat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall    = ($urandom_range(0, 9) < 3);
            gnt      = $urandom_range(0, 1) == 1;
            rvalid   = outs && ($urandom_range(0, 9) < 4);
            rdata    = $urandom;
            redirect = ($urandom_range(0, 19) == 0);
            trap     = ($urandom_range(0, 39) == 0);
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = 32'hFFFFFFF0 | (r & 32'hF);
            if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
            redirect_pc = r;
            #1;
            exp_req = !boot && !outs && (!bvld || !stall);
            n_checks++; if (ivalid !== bvld) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", cyc, ivalid, bvld); end
            if (bvld) begin
                n_checks++; if (instr !== bdat || ipc !== bpc) begin
                    n_fail++; $display("FAIL rnd_instr c%0d got %h@%h want %h@%h", cyc, instr, ipc, bdat, bpc); end
            end
            n_checks++; if (req !== exp_req) begin n_fail++; $display("FAIL rnd_req c%0d got %b want %b", cyc, req, exp_req); end
            if (exp_req) begin
                n_checks++; if (addr !== exp_addr || pc !== exp_addr) begin
                    n_fail++; $display("FAIL rnd_addr c%0d got %h/%h want %h", cyc, addr, pc, exp_addr); end
            end
            n_checks++; if (mis !== exp_mis) begin n_fail++; $display("FAIL rnd_mis c%0d got %b want %b", cyc, mis, exp_mis); end

            flush = !boot && (trap || redirect);
            mcase = MIS_EN && redirect && !trap && (redirect_pc[1:0] != 2'b00);
            if (trap || mcase) tgt = TV;
            else tgt = redirect_pc & 32'hFFFFFFFC;
            if (bvld && !stall) bvld = 0;
            if (rvalid && outs) begin
                outs = 0;
                if (!okill && !flush) begin
                    bvld = 1; bpc = oaddr; bdat = rdata; exp_addr = oaddr + 32'd4;
                end
            end
            if (exp_req && gnt) begin
                outs = 1; oaddr = exp_addr; okill = 0;
            end
            if (flush) begin
                bvld = 0; exp_addr = tgt;
                if (outs) okill = 1;
            end
            exp_mis = flush && mcase;
            boot = 0;
            nxt();
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_trap_priority();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
